// File: rtl/arbitro_rr_mux_if.sv
// Handshake bundle between the round-robin arbiter, its four requesters and the 4:1 mux.
// ARBITRO_CONTADOR_EN adds the per-requester grant counters to the bundle.
interface arbitro_rr_mux_if
`ifdef ARBITRO_CONTADOR_EN
  #(parameter int CUENTA_BITS = 8)
`endif
  ;
  logic [3:0] solicitud;
  logic       pausa;
  logic       enb;
  logic [1:0] selector;
  logic [3:0] concesion;
`ifdef ARBITRO_CONTADOR_EN
  logic [CUENTA_BITS-1:0] cuenta0;
  logic [CUENTA_BITS-1:0] cuenta1;
  logic [CUENTA_BITS-1:0] cuenta2;
  logic [CUENTA_BITS-1:0] cuenta3;

  modport master (input solicitud, input pausa,
                  output enb, output selector, output concesion,
                  output cuenta0, output cuenta1, output cuenta2, output cuenta3);
  modport slave  (output solicitud, output pausa,
                  input enb, input selector, input concesion,
                  input cuenta0, input cuenta1, input cuenta2, input cuenta3);
`else
  modport master (input solicitud, input pausa,
                  output enb, output selector, output concesion);
  modport slave  (output solicitud, output pausa,
                  input enb, input selector, input concesion);
`endif
endinterface

// File: rtl/arbitro_rr_mux.sv
// Round-robin arbiter for a shared 4:1 mux with bounded bursts and downstream pause.
// Optional feature macro: ARBITRO_CONTADOR_EN (per-requester saturating grant counters).
module arbitro_rr_mux #(
  parameter int MAX_RAFAGA = 4
`ifdef ARBITRO_CONTADOR_EN
  , parameter int CUENTA_BITS = 8
`endif
) (
  input  logic              clk,
  input  logic              reset,
  arbitro_rr_mux_if.master  bus
);

  localparam int RW = $clog2(MAX_RAFAGA + 1);
  localparam logic [RW-1:0] RAFAGA_MAX = RW'(MAX_RAFAGA);
  localparam logic [RW-1:0] RAFAGA_UNO = RW'(1);

  typedef enum logic [1:0] {IDLE, GRANT, PAUSA} estado_t;

  estado_t        estado;
  logic [1:0]     puntero;
  logic [RW-1:0]  rafaga;
  logic [1:0]     selector;
  logic [3:0]     concesion;
  logic           enb;

  logic [2:0]     desde_puntero;
  logic [2:0]     desde_siguiente;
  logic [1:0]     siguiente;
  logic           sigue;
  logic           liberar;

  // Returns {found, index} of the first set request scanning p, p+1, ... mod 4.
  function automatic logic [2:0] buscar(input logic [3:0] s, input logic [1:0] p);
    logic [1:0] idx;
    buscar = 3'b000;
    for (int k = 3; k >= 0; k--) begin
      idx = p + 2'(k);
      if (s[idx]) buscar = {1'b1, idx};
    end
  endfunction

  always_comb begin
    siguiente       = selector + 2'd1;
    desde_puntero   = buscar(bus.solicitud, puntero);
    desde_siguiente = buscar(bus.solicitud, siguiente);
    sigue           = bus.solicitud[selector] && (rafaga < RAFAGA_MAX);
    liberar         = (estado != IDLE) && !bus.pausa && !sigue;
  end

  // The held winner lives in selector while in GRANT/PAUSA; release rotates past it,
  // so the old winner is naturally searched last.
  always_ff @(posedge clk) begin
    if (reset) begin
      estado    <= IDLE;
      puntero   <= 2'd0;
      rafaga    <= '0;
      selector  <= 2'd0;
      concesion <= 4'd0;
      enb       <= 1'b0;
    end else if (liberar) begin
      puntero <= siguiente;
      if (desde_siguiente[2]) begin
        estado    <= GRANT;
        selector  <= desde_siguiente[1:0];
        concesion <= 4'b0001 << desde_siguiente[1:0];
        enb       <= 1'b1;
        rafaga    <= RAFAGA_UNO;
      end else begin
        estado    <= IDLE;
        selector  <= 2'd0;
        concesion <= 4'd0;
        enb       <= 1'b0;
        rafaga    <= '0;
      end
    end else begin
      unique case (estado)
        IDLE: begin
          if (!bus.pausa && desde_puntero[2]) begin
            estado    <= GRANT;
            selector  <= desde_puntero[1:0];
            concesion <= 4'b0001 << desde_puntero[1:0];
            enb       <= 1'b1;
            rafaga    <= RAFAGA_UNO;
          end
        end
        GRANT: begin
          if (bus.pausa) begin
            estado    <= PAUSA;
            concesion <= 4'd0;
            enb       <= 1'b0;
          end else begin
            rafaga <= rafaga + RAFAGA_UNO;
          end
        end
        PAUSA: begin
          if (!bus.pausa) begin
            estado    <= GRANT;
            concesion <= 4'b0001 << selector;
            enb       <= 1'b1;
            rafaga    <= rafaga + RAFAGA_UNO;
          end
        end
        default: estado <= IDLE;
      endcase
    end
  end

  assign bus.enb       = enb;
  assign bus.selector  = selector;
  assign bus.concesion = concesion;

`ifdef ARBITRO_CONTADOR_EN
  logic [CUENTA_BITS-1:0] cuenta [4];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) cuenta[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++)
        if (concesion[i] && (cuenta[i] != {CUENTA_BITS{1'b1}}))
          cuenta[i] <= cuenta[i] + {{(CUENTA_BITS-1){1'b0}}, 1'b1};
    end
  end

  assign bus.cuenta0 = cuenta[0];
  assign bus.cuenta1 = cuenta[1];
  assign bus.cuenta2 = cuenta[2];
  assign bus.cuenta3 = cuenta[3];
`endif

endmodule

// File: tb/tb_arbitro_rr_mux.sv
// Bench for arbitro_rr_mux: directed vectors plus a per-cycle behavioural reference.
module tb_arbitro_rr_mux;
  localparam int MAXR = 4;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  arbitro_rr_mux_if bus ();

  arbitro_rr_mux #(.MAX_RAFAGA(MAXR)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: who owns the mux, how many burst cycles it has used, whether it is paused.
  int owner;
  int used;
  int ptr;
  bit paused;
  int cnt [4];

  function automatic int first_from(input logic [3:0] s, input int p);
    for (int k = 0; k < 4; k++)
      if (s[(p + k) % 4]) return (p + k) % 4;
    return -1;
  endfunction

  function automatic int exp_con();
    return (owner >= 0 && !paused) ? (1 << owner) : 0;
  endfunction

  always @(posedge clk) begin
    int w;
    int c;
    c = exp_con();
    for (int i = 0; i < 4; i++)
      if (c[i] && cnt[i] < 255) cnt[i]++;
    if (reset) begin
      owner = -1; used = 0; ptr = 0; paused = 0;
      for (int i = 0; i < 4; i++) cnt[i] = 0;
    end else if (owner < 0) begin
      if (!bus.pausa) begin
        w = first_from(bus.solicitud, ptr);
        if (w >= 0) begin owner = w; used = 1; end
      end
    end else if (bus.pausa) begin
      paused = 1;
    end else if (bus.solicitud[owner] && used < MAXR) begin
      paused = 0;
      used++;
    end else begin
      ptr = (owner + 1) % 4;
      owner = first_from(bus.solicitud, ptr);
      used = (owner >= 0) ? 1 : 0;
      paused = 0;
    end
    #1;
    chk("model_concesion", int'(bus.concesion), exp_con());
    chk("model_enb", int'(bus.enb), (exp_con() != 0) ? 1 : 0);
    chk("model_selector", int'(bus.selector), (owner >= 0) ? owner : 0);
`ifdef ARBITRO_CONTADOR_EN
    chk("model_cuenta0", int'(bus.cuenta0), cnt[0]);
    chk("model_cuenta1", int'(bus.cuenta1), cnt[1]);
    chk("model_cuenta2", int'(bus.cuenta2), cnt[2]);
    chk("model_cuenta3", int'(bus.cuenta3), cnt[3]);
`endif
  end

  task automatic step(input logic [3:0] s, input logic p, input logic r);
    @(negedge clk);
    bus.solicitud = s;
    bus.pausa     = p;
    reset         = r;
    @(posedge clk);
    #2;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1;
    bus.solicitud = 4'b1111;
    bus.pausa = 1'b0;

    // Reset held with all requests pending
    for (int i = 0; i < 2; i++) begin
      step(4'b1111, 1'b0, 1'b1);
      chk("reset_enb", int'(bus.enb), 0);
      chk("reset_concesion", int'(bus.concesion), 0);
      chk("reset_selector", int'(bus.selector), 0);
    end

    // Full load: bursts of four rotating 0,1,2,3 then back to 0
    for (int i = 0; i < 17; i++) begin
      step(4'b1111, 1'b0, 1'b0);
      chk("rr_concesion", int'(bus.concesion), (i < 16) ? (1 << (i / 4)) : 1);
      chk("rr_selector", int'(bus.selector), (i < 16) ? (i / 4) : 0);
      chk("rr_enb", int'(bus.enb), 1);
    end

    // Lone requester regranted across burst boundaries
    step(4'b0000, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      step(4'b0100, 1'b0, 1'b0);
      chk("lone_concesion", int'(bus.concesion), 4);
    end

    // Pause in the middle of a burst on requester 1
    step(4'b0000, 1'b0, 1'b1);
    for (int i = 0; i < 2; i++) begin
      step(4'b0110, 1'b0, 1'b0);
      chk("pre_pause_concesion", int'(bus.concesion), 2);
    end
    for (int i = 0; i < 3; i++) begin
      step(4'b0110, 1'b1, 1'b0);
      chk("pause_concesion", int'(bus.concesion), 0);
      chk("pause_enb", int'(bus.enb), 0);
      chk("pause_selector", int'(bus.selector), 1);
    end
    for (int i = 0; i < 2; i++) begin
      step(4'b0110, 1'b0, 1'b0);
      chk("resume_concesion", int'(bus.concesion), 2);
    end
    step(4'b0110, 1'b0, 1'b0);
    chk("after_burst_concesion", int'(bus.concesion), 4);
    chk("after_burst_selector", int'(bus.selector), 2);

    // Pointer wrap from 3 to 0, then idle
    step(4'b0000, 1'b0, 1'b1);
    step(4'b1000, 1'b0, 1'b0);
    chk("wrap_first", int'(bus.concesion), 8);
    step(4'b0001, 1'b0, 1'b0);
    chk("wrap_concesion", int'(bus.concesion), 1);
    chk("wrap_selector", int'(bus.selector), 0);
    step(4'b0000, 1'b0, 1'b0);
    chk("idle_enb", int'(bus.enb), 0);
    chk("idle_concesion", int'(bus.concesion), 0);

    // Pause arriving on the burst-exhausting edge wins over release
    step(4'b0000, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) step(4'b0001, 1'b0, 1'b0);
    chk("full_burst", int'(bus.concesion), 1);
    step(4'b0001, 1'b1, 1'b0);
    chk("pause_wins", int'(bus.concesion), 0);
    step(4'b0011, 1'b0, 1'b0);
    chk("post_pause_release", int'(bus.concesion), 2);

`ifdef ARBITRO_CONTADOR_EN
    // Twenty counted grant cycles under full load
    step(4'b0000, 1'b0, 1'b1);
    for (int i = 0; i < 21; i++) step(4'b1111, 1'b0, 1'b0);
    chk("cuenta0", int'(bus.cuenta0), 8);
    chk("cuenta1", int'(bus.cuenta1), 4);
    chk("cuenta2", int'(bus.cuenta2), 4);
    chk("cuenta3", int'(bus.cuenta3), 4);
`endif

    step(4'b0000, 1'b0, 1'b0);
    step(4'b0000, 1'b0, 1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
